// File: rtl/unlock_pkg.sv
// Shared definitions for the 4-input unlock-sequence protocol: FSM encoding,
// step count and the 12-entry {i4,i3,i2,i1} vector ROM.
package unlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int unsigned NUM_STEPS = 12;
    localparam int unsigned VEC_W     = 4;
    localparam int unsigned HOLD_W    = 8;
    localparam int unsigned IDX_W     = 4;

    // Element [k] is the vector for step k; don't-care lines are 0.
    localparam logic [NUM_STEPS-1:0][VEC_W-1:0] VEC_ROM = {
        4'h0, 4'h1, 4'h4, 4'h8,
        4'h0, 4'h8, 4'h1, 4'h2,
        4'h4, 4'h0, 4'h9, 4'h4
    };

    // Out-of-range steps read as all-zero lines.
    function automatic logic [VEC_W-1:0] rom_vec(input logic [IDX_W-1:0] s);
        rom_vec = '0;
        if (s < IDX_W'(NUM_STEPS)) rom_vec = VEC_ROM[s];
    endfunction

endpackage

// File: rtl/unlock_hold_ctr.sv
// 8-bit loadable down-counter that times how long each vector is held.
module unlock_hold_ctr
    import unlock_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              dec,
    output logic              zero_c
);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - HOLD_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/unlock_seq_tx.sv
// Transmit side of the unlock-sequence protocol: drives the 12-step vector
// sequence on i1..i4. Optional UNLOCK_ERR_INJECT_EN inverts i3 at one step.
module unlock_seq_tx
    import unlock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned STEP_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef UNLOCK_ERR_INJECT_EN
    input  logic              inject,
    input  logic [3:0]        inj_step,
`endif
    output logic              i1,
    output logic              i2,
    output logic              i3,
    output logic              i4,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic              hold_zero;
    logic              accept;
    logic              advance;
    logic [STEP_W-1:0] step_nxt;
    logic [VEC_W-1:0]  vec_first;
    logic [VEC_W-1:0]  vec_next;

    assign accept   = (state == ST_IDLE) && start;
    assign advance  = (state == ST_DRIVE) && !abort && hold_zero && (step != LAST_STEP);
    assign step_nxt = step + STEP_W'(1);

`ifdef UNLOCK_ERR_INJECT_EN
    // Injection target is latched at start so mid-flight input changes are ignored.
    logic             inj_en_q;
    logic [3:0]       inj_step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inj_en_q   <= 1'b0;
            inj_step_q <= '0;
        end else if (accept) begin
            inj_en_q   <= inject;
            inj_step_q <= inj_step;
        end
    end

    assign vec_first = rom_vec(IDX_W'(0))
                     ^ ((inject && (inj_step == 4'd0)) ? 4'b0100 : 4'b0000);
    assign vec_next  = rom_vec(IDX_W'(step_nxt))
                     ^ ((inj_en_q && (inj_step_q == 4'(step_nxt))) ? 4'b0100 : 4'b0000);
`else
    assign vec_first = rom_vec(IDX_W'(0));
    assign vec_next  = rom_vec(IDX_W'(step_nxt));
`endif

    unlock_hold_ctr u_hold (
        .clk      (clk),
        .reset    (reset),
        .clr      ((state == ST_DRIVE) && abort),
        .load     (accept || advance),
        .load_val (HOLD_LOAD),
        .dec      ((state == ST_DRIVE) && !abort),
        .zero_c   (hold_zero)
    );

    // Sequencer: reset > abort > hold/step progression.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            {i4, i3, i2, i1} <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            step             <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        {i4, i3, i2, i1} <= vec_first;
                        step             <= '0;
                        busy             <= 1'b1;
                        state            <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        {i4, i3, i2, i1} <= '0;
                        step             <= '0;
                        busy             <= 1'b0;
                        state            <= ST_IDLE;
                    end else if (hold_zero) begin
                        if (step != LAST_STEP) begin
                            step             <= step_nxt;
                            {i4, i3, i2, i1} <= vec_next;
                        end else begin
                            {i4, i3, i2, i1} <= '0;
                            step             <= '0;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state            <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    {i4, i3, i2, i1} <= '0;
                    step             <= '0;
                    busy             <= 1'b0;
                    done             <= 1'b0;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unlock_seq_tx.sv
// Bench for unlock_seq_tx: table-driven vectors with a scoreboard queue, hand
// sequences for abort/reset/retrigger, and a second instance with HOLD_CYCLES=3.
module tb_unlock_seq_tx;

    typedef struct {
        logic       rst;
        logic       start;
        logic       abort;
        logic [3:0] lines;
        logic       busy;
        logic       done;
        logic [3:0] step;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic       i1, i2, i3, i4, busy, done;
    logic [3:0] step;

    logic       reset3, start3, abort3;
    logic       j1, j2, j3, j4, busy3, done3;
    logic [3:0] step3;

`ifdef UNLOCK_ERR_INJECT_EN
    logic       inject, inject3;
    logic [3:0] inj_step, inj_step3;
`endif

    int errors = 0;
    int checks = 0;

    vec_t       tbl[$];
    vec_t       sb[$];
    logic [3:0] exp_rom [12];

    always #5 clk = ~clk;

    unlock_seq_tx #(.HOLD_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef UNLOCK_ERR_INJECT_EN
        .inject(inject), .inj_step(inj_step),
`endif
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .busy(busy), .done(done), .step(step)
    );

    unlock_seq_tx #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .abort(abort3),
`ifdef UNLOCK_ERR_INJECT_EN
        .inject(inject3), .inj_step(inj_step3),
`endif
        .i1(j1), .i2(j2), .i3(j3), .i4(j4),
        .busy(busy3), .done(done3), .step(step3)
    );

    task automatic cmp(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got lines=%h busy=%b done=%b step=%0d, want lines=%h busy=%b done=%b step=%0d",
                     name, act[9:6], act[5], act[4], act[3:0], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Scoreboard: each driven cycle's expectation is checked just after the next edge.
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("sb", {i4, i3, i2, i1, busy, done, step},
                {e.lines, e.busy, e.done, e.step});
        end
    end

    task automatic add(input logic r, input logic s, input logic a,
                       input logic [3:0] l, input logic b, input logic d, input logic [3:0] st);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a;
        v.lines = l; v.busy = b; v.done = d; v.step = st;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset = v.rst; start = v.start; abort = v.abort;
        sb.push_back(v);
    endtask

    task automatic drv(input logic r, input logic s, input logic a,
                       input logic [3:0] l, input logic b, input logic d, input logic [3:0] st);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a;
        v.lines = l; v.busy = b; v.done = d; v.step = st;
        drive(v);
    endtask

    // Full transmission; optional retrigger while step k is visible, optional i3 flip at inj_at.
    task automatic full_seq(input int retrig_at, input int inj_at);
        drv(0, 1, 0, exp_rom[0] ^ ((inj_at == 0) ? 4'h4 : 4'h0), 1, 0, 4'd0);
        for (int k = 1; k < 12; k++)
            drv(0, (k - 1 == retrig_at), 0, exp_rom[k] ^ ((inj_at == k) ? 4'h4 : 4'h0), 1, 0, 4'(k));
        drv(0, (retrig_at == 11), 0, 4'h0, 0, 1, 4'd0);
        drv(0, 0, 0, 4'h0, 0, 0, 4'd0);
    endtask

    // Transmission cut short by abort or reset while step stop_at is visible.
    task automatic cut_seq(input int stop_at, input logic use_reset);
        drv(0, 1, 0, exp_rom[0], 1, 0, 4'd0);
        for (int k = 1; k <= stop_at; k++)
            drv(0, 0, 0, exp_rom[k], 1, 0, 4'(k));
        drv(use_reset, 0, !use_reset, 4'h0, 0, 0, 4'd0);
        for (int k = 0; k < 14; k++)
            drv(0, 0, 0, 4'h0, 0, 0, 4'd0);
    endtask

    initial begin
        exp_rom = '{4'h4, 4'h9, 4'h0, 4'h4, 4'h2, 4'h1, 4'h8, 4'h0, 4'h8, 4'h4, 4'h1, 4'h0};
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        reset3 = 1'b1; start3 = 1'b0; abort3 = 1'b0;
`ifdef UNLOCK_ERR_INJECT_EN
        inject = 1'b0; inj_step = 4'd0; inject3 = 1'b0; inj_step3 = 4'd0;
`endif

        // Nominal HOLD_CYCLES=1 run plus handshake corners around done and idle.
        add(1, 0, 0, 4'h0, 0, 0, 4'd0);
        add(1, 1, 0, 4'h0, 0, 0, 4'd0);
        add(0, 1, 0, 4'h4, 1, 0, 4'd0);
        add(0, 0, 0, 4'h9, 1, 0, 4'd1);
        add(0, 0, 0, 4'h0, 1, 0, 4'd2);
        add(0, 0, 0, 4'h4, 1, 0, 4'd3);
        add(0, 0, 0, 4'h2, 1, 0, 4'd4);
        add(0, 0, 0, 4'h1, 1, 0, 4'd5);
        add(0, 0, 0, 4'h8, 1, 0, 4'd6);
        add(0, 0, 0, 4'h0, 1, 0, 4'd7);
        add(0, 0, 0, 4'h8, 1, 0, 4'd8);
        add(0, 0, 0, 4'h4, 1, 0, 4'd9);
        add(0, 0, 0, 4'h1, 1, 0, 4'd10);
        add(0, 0, 0, 4'h0, 1, 0, 4'd11);
        add(0, 0, 0, 4'h0, 0, 1, 4'd0);
        add(0, 1, 1, 4'h0, 0, 0, 4'd0);
        add(0, 1, 0, 4'h4, 1, 0, 4'd0);
        add(0, 1, 1, 4'h0, 0, 0, 4'd0);
        add(0, 1, 1, 4'h4, 1, 0, 4'd0);
        add(0, 0, 0, 4'h9, 1, 0, 4'd1);
        add(1, 1, 1, 4'h0, 0, 0, 4'd0);
        add(0, 0, 1, 4'h0, 0, 0, 4'd0);
        foreach (tbl[i]) drive(tbl[i]);

        full_seq(5, -1);
        full_seq(11, -1);
        cut_seq(6, 1'b0);
        full_seq(-1, -1);
        cut_seq(9, 1'b1);
        full_seq(-1, -1);

`ifdef UNLOCK_ERR_INJECT_EN
        @(negedge clk); inject = 1'b1; inj_step = 4'd2;
        full_seq(-1, 2);
        @(negedge clk); inject = 1'b1; inj_step = 4'd14;
        full_seq(-1, -1);
        @(negedge clk); inject = 1'b0; inj_step = 4'd0;
`endif

        @(negedge clk); reset = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end

        // HOLD_CYCLES=3: each vector held 3 cycles, done 37 cycles after start.
        @(posedge clk); #1;
        cmp("h3_reset", {j4, j3, j2, j1, busy3, done3, step3}, 10'd0);
        @(negedge clk); reset3 = 1'b0; start3 = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            @(posedge clk); #1;
            start3 = 1'b0;
            if (c <= 36)
                cmp("h3_drive", {j4, j3, j2, j1, busy3, done3, step3},
                    {exp_rom[(c - 1) / 3], 1'b1, 1'b0, 4'((c - 1) / 3)});
            else if (c == 37)
                cmp("h3_done", {j4, j3, j2, j1, busy3, done3, step3}, {4'h0, 1'b0, 1'b1, 4'd0});
            else
                cmp("h3_idle", {j4, j3, j2, j1, busy3, done3, step3}, 10'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
